// File: rtl/link_slave_fsm.sv
// ---------------------------------------------------------------------------
// link_slave_fsm
//   Responder end of a 4-phase req/ack byte link. Captures one byte per
//   handshake, holds ack until req falls, packs BURST_LEN bytes into a burst
//   word, aborts a burst that stalls for TIMEOUT idle cycles, and flags data
//   that changes while the handshake is open.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   req          request from initiator (data valid while high)
//   data         byte from initiator
//   ack          registered acknowledge to initiator
//   byte_out     last captured byte
//   byte_valid   1-cycle pulse, byte_out updated
//   burst_word   assembled burst, byte 0 in the LSBs
//   burst_valid  1-cycle pulse, burst_word updated
//   burst_abort  1-cycle pulse, partial burst discarded on timeout
//   byte_idx     index of the next byte expected within the burst
//   err_data     sticky flag: data changed while req and ack were both high
//   burst_csum   mod-2^DATA_W sum of the last completed burst
//
// Optional feature macro: LINK_SLAVE_CSUM_EN
//   defined   -> running byte sum kept, burst_csum loaded on burst completion
//   undefined -> burst_csum tied to 0, no accumulator built
// ---------------------------------------------------------------------------
module link_slave_fsm #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64,
    localparam int IDX_W    = $clog2(BURST_LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic [DATA_W-1:0]             data,
    output logic                          ack,
    output logic [DATA_W-1:0]             byte_out,
    output logic                          byte_valid,
    output logic [DATA_W*BURST_LEN-1:0]   burst_word,
    output logic                          burst_valid,
    output logic                          burst_abort,
    output logic [IDX_W-1:0]              byte_idx,
    output logic                          err_data,
    output logic [DATA_W-1:0]             burst_csum
);

    // Counter only ever needs to hold TIMEOUT-1; the abort fires on the
    // increment that would take it to TIMEOUT.
    localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    typedef enum logic {
        WAIT_REQ = 1'b0,
        ACK_HIGH = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [DATA_W-1:0]             byte_q, byte_d;
    logic [DATA_W-1:0]             shadow_q, shadow_d;
    logic                          byte_valid_q, byte_valid_d;
    logic                          burst_valid_q, burst_valid_d;
    logic                          burst_abort_q, burst_abort_d;
    logic                          err_q, err_d;
    logic [DATA_W*BURST_LEN-1:0]   word_q, word_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    logic                          capture;
    logic                          is_last;
    logic [DATA_W*BURST_LEN-1:0]   assembled;

    // Slots hold bytes 0..BURST_LEN-2; the final byte goes straight from the
    // data bus into the burst word on the completing edge.
    logic [DATA_W-1:0]             slot_q [BURST_LEN-1];
    logic [DATA_W-1:0]             slot_d [BURST_LEN-1];

    assign capture = (state_q == WAIT_REQ) && req;
    assign is_last = (idx_q == LAST_IDX);

    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN - 1; gi++) begin : g_slot
            assign slot_d[gi] = (capture && (idx_q == IDX_W'(gi))) ? data : slot_q[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_q[gi] <= '0;
                end else begin
                    slot_q[gi] <= slot_d[gi];
                end
            end

            assign assembled[gi*DATA_W +: DATA_W] = slot_q[gi];
        end
    endgenerate

    assign assembled[(BURST_LEN-1)*DATA_W +: DATA_W] = data;

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        shadow_d      = shadow_q;
        byte_valid_d  = 1'b0;
        burst_valid_d = 1'b0;
        burst_abort_d = 1'b0;
        err_d         = err_q;
        word_d        = word_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;

        case (state_q)
            WAIT_REQ: begin
                if (req) begin
                    // Capture wins over a coincident timeout.
                    byte_d       = data;
                    shadow_d     = data;
                    byte_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ACK_HIGH;
                    if (is_last) begin
                        word_d        = assembled;
                        burst_valid_d = 1'b1;
                        idx_d         = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (idx_q != '0) begin
                    if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TMO_LAST))) begin
                        idx_d         = '0;
                        burst_abort_d = 1'b1;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ACK_HIGH: begin
                if (!req) begin
                    state_d = WAIT_REQ;
                end else if (data != shadow_q) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_REQ;
            byte_q        <= '0;
            shadow_q      <= '0;
            byte_valid_q  <= 1'b0;
            burst_valid_q <= 1'b0;
            burst_abort_q <= 1'b0;
            err_q         <= 1'b0;
            word_q        <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            shadow_q      <= shadow_d;
            byte_valid_q  <= byte_valid_d;
            burst_valid_q <= burst_valid_d;
            burst_abort_q <= burst_abort_d;
            err_q         <= err_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
        end
    end

`ifdef LINK_SLAVE_CSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        sum_d  = sum_q;
        csum_d = csum_q;
        if (capture) begin
            if (is_last) begin
                csum_d = sum_q + data;
                sum_d  = '0;
            end else begin
                sum_d = sum_q + data;
            end
        end else if (burst_abort_d) begin
            sum_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            csum_q <= '0;
        end else begin
            sum_q  <= sum_d;
            csum_q <= csum_d;
        end
    end

    assign burst_csum = csum_q;
`else
    assign burst_csum = '0;
`endif

    assign ack         = (state_q == ACK_HIGH);
    assign byte_out    = byte_q;
    assign byte_valid  = byte_valid_q;
    assign burst_word  = word_q;
    assign burst_valid = burst_valid_q;
    assign burst_abort = burst_abort_q;
    assign byte_idx    = idx_q;
    assign err_data    = err_q;

endmodule

// File: tb/tb_link_slave_fsm.sv
// ---------------------------------------------------------------------------
// tb_link_slave_fsm
//   Directed bench for link_slave_fsm (DATA_W=8, BURST_LEN=4, TIMEOUT=8).
//   A table of per-cycle {inputs, expected outputs} records covers the
//   normal burst traffic; hand-written sequences cover timeout abort,
//   unstable data and reset mid-handshake.
// ---------------------------------------------------------------------------
module tb_link_slave_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [7:0]  data;
    logic        ack;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] burst_word;
    logic        burst_valid;
    logic        burst_abort;
    logic [1:0]  byte_idx;
    logic        err_data;
    logic [7:0]  burst_csum;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    link_slave_fsm #(
        .DATA_W    (8),
        .BURST_LEN (4),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data        (data),
        .ack         (ack),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .burst_word  (burst_word),
        .burst_valid (burst_valid),
        .burst_abort (burst_abort),
        .byte_idx    (byte_idx),
        .err_data    (err_data),
        .burst_csum  (burst_csum)
    );

    typedef struct {
        logic        req;
        logic [7:0]  data;
        logic        ack;
        logic        bv;
        logic [7:0]  bo;
        logic        burstv;
        logic [31:0] bw;
        logic [1:0]  idx;
        logic [7:0]  cs;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_bw  = 32'h0;
    logic [1:0]  exp_idx = 2'd0;
    logic [7:0]  exp_cs  = 8'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_csum(input string nm, input logic [7:0] exp);
`ifdef LINK_SLAVE_CSUM_EN
        chk(nm, {24'h0, burst_csum}, {24'h0, exp});
`else
        chk(nm, {24'h0, burst_csum}, 32'h0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One byte handshake: capture vector, `hold` more req-high cycles, then
    // req low. Expected burst word / checksum are hand-supplied for the last byte.
    task add_byte(input logic [7:0] d, input int hold, input logic last,
                  input logic [31:0] word, input logic [7:0] cs);
        if (last) begin
            exp_bw  = word;
            exp_cs  = cs;
            exp_idx = 2'd0;
        end else begin
            exp_idx = exp_idx + 2'd1;
        end
        vq.push_back('{1'b1, d, 1'b1, 1'b1, d, last, exp_bw, exp_idx, exp_cs});
        for (int h = 0; h < hold; h++)
            vq.push_back('{1'b1, d, 1'b1, 1'b0, d, 1'b0, exp_bw, exp_idx, exp_cs});
        vq.push_back('{1'b0, d, 1'b0, 1'b0, d, 1'b0, exp_bw, exp_idx, exp_cs});
    endtask

    // Hand-sequence handshake with a 2-cycle hold.
    task automatic send_byte(input logic [7:0] d, input logic exp_burstv);
        req  = 1'b1;
        data = d;
        step();
        chk("hs_ack_rise", {31'h0, ack}, 32'h1);
        chk("hs_byte_valid", {31'h0, byte_valid}, 32'h1);
        chk("hs_byte_out", {24'h0, byte_out}, {24'h0, d});
        chk("hs_burst_valid", {31'h0, burst_valid}, {31'h0, exp_burstv});
        step();
        chk("hs_bv_single", {31'h0, byte_valid}, 32'h0);
        step();
        req = 1'b0;
        step();
        chk("hs_ack_fall", {31'h0, ack}, 32'h0);
    endtask

    initial begin
        int abort_at;
        logic seen_abort;

        // Burst A, 2-cycle hold.
        add_byte(8'hA0, 2, 1'b0, 32'h0, 8'h0);
        add_byte(8'hA1, 2, 1'b0, 32'h0, 8'h0);
        add_byte(8'hA2, 2, 1'b0, 32'h0, 8'h0);
        add_byte(8'hA3, 2, 1'b1, 32'hA3A2A1A0, 8'h86);
        // Back-to-back bursts, 1-cycle hold.
        add_byte(8'h00, 1, 1'b0, 32'h0, 8'h0);
        add_byte(8'h11, 1, 1'b0, 32'h0, 8'h0);
        add_byte(8'h22, 1, 1'b0, 32'h0, 8'h0);
        add_byte(8'h33, 1, 1'b1, 32'h33221100, 8'h66);
        add_byte(8'h44, 1, 1'b0, 32'h0, 8'h0);
        add_byte(8'h55, 1, 1'b0, 32'h0, 8'h0);
        add_byte(8'h66, 1, 1'b0, 32'h0, 8'h0);
        add_byte(8'h77, 1, 1'b1, 32'h77665544, 8'h76);
        // Long hold of 10 cycles on the first byte of a burst.
        add_byte(8'h10, 10, 1'b0, 32'h0, 8'h0);
        add_byte(8'h11, 2, 1'b0, 32'h0, 8'h0);
        add_byte(8'h12, 2, 1'b0, 32'h0, 8'h0);
        add_byte(8'h13, 2, 1'b1, 32'h13121110, 8'h46);

        // Reset.
        rst  = 1'b1;
        req  = 1'b0;
        data = 8'h0;
        step();
        step();
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_byte_out", {24'h0, byte_out}, 32'h0);
        chk("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        chk("rst_burst_word", burst_word, 32'h0);
        chk("rst_burst_valid", {31'h0, burst_valid}, 32'h0);
        chk("rst_burst_abort", {31'h0, burst_abort}, 32'h0);
        chk("rst_byte_idx", {30'h0, byte_idx}, 32'h0);
        chk("rst_err_data", {31'h0, err_data}, 32'h0);
        chk_csum("rst_csum", 8'h0);
        rst = 1'b0;
        step();

        // Table-driven section.
        for (int i = 0; i < vq.size(); i++) begin
            req  = vq[i].req;
            data = vq[i].data;
            step();
            chk($sformatf("v%0d_ack", i), {31'h0, ack}, {31'h0, vq[i].ack});
            chk($sformatf("v%0d_byte_valid", i), {31'h0, byte_valid}, {31'h0, vq[i].bv});
            chk($sformatf("v%0d_byte_out", i), {24'h0, byte_out}, {24'h0, vq[i].bo});
            chk($sformatf("v%0d_burst_valid", i), {31'h0, burst_valid}, {31'h0, vq[i].burstv});
            chk($sformatf("v%0d_burst_word", i), burst_word, vq[i].bw);
            chk($sformatf("v%0d_byte_idx", i), {30'h0, byte_idx}, {30'h0, vq[i].idx});
            chk($sformatf("v%0d_abort", i), {31'h0, burst_abort}, 32'h0);
            chk($sformatf("v%0d_err", i), {31'h0, err_data}, 32'h0);
            chk_csum($sformatf("v%0d_csum", i), vq[i].cs);
        end

        // Idle with no burst open must never abort.
        seen_abort = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            seen_abort = seen_abort | burst_abort;
        end
        chk("idle_no_abort", {31'h0, seen_abort}, 32'h0);

        // Timeout: two bytes, then idle until abort.
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b0);
        chk("tmo_idx_before", {30'h0, byte_idx}, 32'h2);
        abort_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (burst_abort && abort_at == 0) abort_at = k;
            if (abort_at != 0) break;
        end
        chk("tmo_abort_cycle", {31'h0, (abort_at == 8 || abort_at == 9)}, 32'h1);
        chk("tmo_idx_after", {30'h0, byte_idx}, 32'h0);
        chk("tmo_word_kept", burst_word, 32'h13121110);
        chk_csum("tmo_csum_kept", 8'h46);
        step();
        chk("tmo_abort_single", {31'h0, burst_abort}, 32'h0);
        send_byte(8'hB0, 1'b0);
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hB3, 1'b1);
        chk("tmo_next_word", burst_word, 32'hB3B2B1B0);
        chk("tmo_next_idx", {30'h0, byte_idx}, 32'h0);
        chk_csum("tmo_next_csum", 8'hC6);

        // Unstable data while the handshake is open.
        req  = 1'b1;
        data = 8'h5A;
        step();
        chk("err_ack", {31'h0, ack}, 32'h1);
        chk("err_before", {31'h0, err_data}, 32'h0);
        data = 8'h5B;
        step();
        chk("err_set", {31'h0, err_data}, 32'h1);
        chk("err_byte_out", {24'h0, byte_out}, 32'h5A);
        chk("err_ack_held", {31'h0, ack}, 32'h1);
        req  = 1'b0;
        data = 8'h00;
        step();
        chk("err_ack_fall", {31'h0, ack}, 32'h0);
        step();
        step();
        chk("err_sticky", {31'h0, err_data}, 32'h1);

        // Second byte open with ack high, then reset.
        req  = 1'b1;
        data = 8'h5C;
        step();
        chk("rmid_ack", {31'h0, ack}, 32'h1);
        chk("rmid_idx", {30'h0, byte_idx}, 32'h2);
        chk("rmid_err_sticky", {31'h0, err_data}, 32'h1);
        rst = 1'b1;
        step();
        chk("rmid_ack_drop", {31'h0, ack}, 32'h0);
        chk("rmid_idx_clr", {30'h0, byte_idx}, 32'h0);
        chk("rmid_err_clr", {31'h0, err_data}, 32'h0);
        chk("rmid_word_clr", burst_word, 32'h0);
        rst = 1'b0;
        req = 1'b0;
        step();
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b1);
        chk("rmid_next_word", burst_word, 32'hC3C2C1C0);
        chk_csum("rmid_next_csum", 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/link_slave_fsm.md
Name: link_slave_fsm

Overview:
- Responder end of the 4-phase req/ack byte link; the initiator drives req, data[7:0] and waits on ack.
- Captures one byte per handshake, raises ack, and releases ack only after req falls.
- Packs BURST_LEN bytes into a burst word and pulses burst_valid after the last byte.
- Sits between the link initiator and the downstream consumer; also aborts stalled bursts and flags unstable data.

Parameters:
DATA_W, 8, width of data bus and captured byte
BURST_LEN, 4, bytes per burst (2..16)
TIMEOUT, 64, max idle cycles between bytes inside a burst before abort; 0 disables

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req  input  1  request from initiator; data valid while high
data  input  DATA_W  byte from initiator
ack  output  1  registered acknowledge to initiator
byte_out  output  DATA_W  last captured byte
byte_valid  output  1  1-cycle pulse, byte_out updated
burst_word  output  DATA_W*BURST_LEN  assembled burst; byte 0 in LSBs
burst_valid  output  1  1-cycle pulse, burst_word updated
burst_abort  output  1  1-cycle pulse, partial burst discarded on timeout
byte_idx  output  clog2(BURST_LEN)  index of the next byte expected
err_data  output  1  sticky: data changed while req and ack both high
burst_csum  output  DATA_W  checksum of the last completed burst (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at posedge): all outputs 0, state WAIT_REQ, byte_idx 0, timeout counter 0. Reset mid-handshake drops ack on that edge; the partial burst is discarded.
- State WAIT_REQ (ack=0): on posedge with req=1:
  - byte_out<=data, shadow<=data, ack<=1, byte_valid<=1 (one cycle).
  - Byte is written into the burst slot byte_idx; go to ACK_HIGH.
  - If byte_idx==BURST_LEN-1: burst_word<=all slots including this byte, burst_valid<=1 on the same edge as byte_valid, byte_idx<=0. Otherwise byte_idx<=byte_idx+1.
  - Latency: req high in cycle N gives ack=1 in cycle N+1.
- State ACK_HIGH (ack=1): on posedge with req=0, ack<=0 and go to WAIT_REQ. Latency: req low in cycle M gives ack=0 in cycle M+1. Ack is held for as long as req stays high; there is no maximum.
- Initiator hold: the initiator keeps req high for 2 cycles after seeing ack. Any req-high duration of 1 or more cycles after ack is legal.
- In WAIT_REQ, req is sampled only when ack=0, so no byte is captured twice. If req is still high on the edge where ack falls, it is treated as a new byte at the next posedge (back-to-back initiator).
- Data check: in ACK_HIGH with req=1, if data!=shadow then err_data<=1. err_data is cleared only by rst.
- Timeout:
  - The counter increments each cycle in WAIT_REQ while byte_idx!=0 and req=0.
  - It clears on any capture.
  - When it reaches TIMEOUT (TIMEOUT>0): byte_idx<=0, burst_abort pulses 1 cycle, counter<=0, burst_word is unchanged.
  - If req=1 on the same edge the counter reaches TIMEOUT, the capture wins: no abort, normal capture.
- byte_valid, burst_valid and burst_abort are registered single-cycle pulses, never asserted in two consecutive cycles by the same byte.

Optional Feature:
- Macro: LINK_SLAVE_CSUM_EN.
- Defined:
  - A running sum mod 2^DATA_W of burst bytes is kept.
  - On burst completion, burst_csum<=sum including the final byte, and the running sum resets to 0.
  - Timeout abort and rst also reset the running sum; burst_csum keeps its value on abort.
- Undefined: burst_csum tied to 0 and no accumulator logic is built.

Test Plan:
- Single burst: initiator sends A0,A1,A2,A3 with a 2-cycle req hold after ack → 4 byte_valid pulses with byte_out A0..A3; burst_valid with burst_word=32'hA3A2A1A0; ack=1 exactly one cycle after each req rise and 0 one cycle after each req fall; err_data=0; with CSUM_EN, burst_csum=8'h86.
- Back-to-back bursts: two bursts 00,11,22,33 then 44,55,66,77 → burst_word 32'h33221100 then 32'h77665544; byte_idx returns to 0 after each.
- Long hold: req held high 10 cycles after ack → ack stays 1 for all 10 cycles, only one byte_valid, then ack falls 1 cycle after req.
- Timeout: TIMEOUT=8; send 2 bytes, then idle 8 cycles → burst_abort pulse and byte_idx=0; the next 4 bytes B0..B3 produce burst_word 32'hB3B2B1B0.
- Unstable data: change data from 5A to 5B while req=1 and ack=1 → err_data=1 and stays 1 until rst; byte_out remains 5A.
- Reset mid-handshake: assert rst while ack=1 after byte 2 → ack=0 on the next edge; byte_idx=0; a following full burst C0..C3 gives 32'hC3C2C1C0.
